mda_adc_poller: RTL and testbench

Avalon-MM read master: the initiator side of the ADC slave's register interface (channel registers 0..NUM_CH-1, 12-bit results, active-low control).
- Sweeps all channel registers once per PERIOD cycles while enabled.
- Pushes {channel, sample} into an internal FIFO that feeds a ready/valid sample stream to the hydrophone/sensor pipeline.
- Flags dropped samples and missed sweeps.

---
 rtl/mda_adc_poller_pkg.sv | 16 +
 rtl/mda_adc_poller_if.sv | 37 +++
 rtl/mda_adc_poller_fifo.sv | 44 ++++
 rtl/mda_adc_poller.sv | 156 +++++++++++++++
 tb/tb_mda_adc_poller.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mda_adc_poller_pkg.sv
// mda_adc_pkg: shared constants, FSM states and FIFO entry layout for the ADC poller (MDA_ADC_POLLER_TIMESTAMP_EN adds a timestamp field)
package mda_adc_pkg;
    localparam int ADC_DATA_W = 12;
    localparam int ADC_NUM_CH = 8;
    localparam int ADC_ADDR_W = $clog2(ADC_NUM_CH);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_PUSH} state_e;

    typedef struct packed {
        logic [ADC_ADDR_W-1:0] ch;
        logic [ADC_DATA_W-1:0] data;
`ifdef MDA_ADC_POLLER_TIMESTAMP_EN
        logic [31:0]           ts;
`endif
    } adc_entry_t;
endpackage

// File: rtl/mda_adc_poller_if.sv
// mda_adc_poller_if: Avalon-MM read bus toward the ADC plus the ready/valid sample stream (MDA_ADC_POLLER_TIMESTAMP_EN adds sample_ts)
interface mda_adc_poller_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 12
);
    logic              chipselect_n;
    logic              read_n;
    logic              write_n;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              sample_valid;
    logic              sample_ready;
    logic [ADDR_W-1:0] sample_ch;
    logic [DATA_W-1:0] sample_data;
`ifdef MDA_ADC_POLLER_TIMESTAMP_EN
    logic [31:0]       sample_ts;
`endif

    modport master (
        output chipselect_n, read_n, write_n, addr, writedata,
        output sample_valid, sample_ch, sample_data,
`ifdef MDA_ADC_POLLER_TIMESTAMP_EN
        output sample_ts,
`endif
        input  readdata, sample_ready
    );

    modport slave (
        input  chipselect_n, read_n, write_n, addr, writedata,
        input  sample_valid, sample_ch, sample_data,
`ifdef MDA_ADC_POLLER_TIMESTAMP_EN
        input  sample_ts,
`endif
        output readdata, sample_ready
    );
endinterface

// File: rtl/mda_adc_poller_fifo.sv
// mda_sync_fifo: single-clock first-word-fall-through FIFO; DEPTH must be a power of 2 (>= 2)
module mda_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            wr_ptr <= wr_ptr + (do_push ? 1'b1 : 1'b0);
            rd_ptr <= rd_ptr + (do_pop ? 1'b1 : 1'b0);
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/mda_adc_poller.sv
// mda_adc_poller: periodic Avalon-MM sweep of ADC channel registers into a sample FIFO; `define MDA_ADC_POLLER_TIMESTAMP_EN to tag samples with a sweep timestamp
module mda_adc_poller
    import mda_adc_pkg::*;
#(
    parameter int NUM_CH       = ADC_NUM_CH,
    parameter int ADDR_W       = 3,
    parameter int DATA_W       = ADC_DATA_W,
    parameter int READ_LATENCY = 1,
    parameter int PERIOD       = 5000,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic             master_clk,
    input  logic             master_reset_n,
    input  logic             enable,
    input  logic             clear_flags,
    mda_adc_poller_if.master bus,
    output logic             overflow,
    output logic             missed_sweep,
    output logic             busy
);
    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] ISSUE = ST_ISSUE;
    localparam logic [1:0] WAIT  = ST_WAIT;
    localparam logic [1:0] PUSH  = ST_PUSH;
    localparam int CW = $clog2(PERIOD);
    localparam int LW = READ_LATENCY > 1 ? $clog2(READ_LATENCY) : 1;
`ifdef MDA_ADC_POLLER_TIMESTAMP_EN
    localparam int FW = ADDR_W + DATA_W + 32;
`else
    localparam int FW = ADDR_W + DATA_W;
`endif

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [LW-1:0]     lat;
    logic [ADDR_W-1:0] ch;
    logic [DATA_W-1:0] data;
    logic              pending;
    logic              tick;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FW-1:0]     fifo_in;
    logic [FW-1:0]     fifo_out;
    logic              unused_rd;

    assign tick      = enable && cnt == CW'(PERIOD - 1);
    assign push      = state == PUSH;
    assign pop       = bus.sample_valid && bus.sample_ready;
    assign busy      = state != IDLE;
    assign unused_rd = ^bus.readdata;

    // Strobes decode straight from state so an async reset drops them at once.
    assign bus.chipselect_n = state != ISSUE;
    assign bus.read_n       = state != ISSUE;
    assign bus.addr         = ch;
    assign bus.write_n      = 1'b1;
    assign bus.writedata    = '0;
    assign bus.sample_valid = !fifo_empty;

    // Sweep period counter; held at 0 while disabled.
    always_ff @(posedge master_clk or negedge master_reset_n) begin
        if (!master_reset_n) cnt <= '0;
        else cnt <= (!enable || tick) ? '0 : cnt + 1'b1;
    end

    // At most one sweep is queued; a newer tick wins over the dequeue.
    always_ff @(posedge master_clk or negedge master_reset_n) begin
        if (!master_reset_n) pending <= 1'b0;
        else if (!enable) pending <= 1'b0;
        else if (tick) pending <= 1'b1;
        else if (state == IDLE) pending <= 1'b0;
    end

    // Sticky flags; clear_flags beats a same-cycle set.
    always_ff @(posedge master_clk or negedge master_reset_n) begin
        if (!master_reset_n) begin
            overflow     <= 1'b0;
            missed_sweep <= 1'b0;
        end else if (clear_flags) begin
            overflow     <= 1'b0;
            missed_sweep <= 1'b0;
        end else begin
            if (push && fifo_full && !pop) overflow <= 1'b1;
            if (tick && pending) missed_sweep <= 1'b1;
        end
    end

    // Per channel: one strobe cycle, READ_LATENCY wait cycles, one push cycle.
    always_ff @(posedge master_clk or negedge master_reset_n) begin
        if (!master_reset_n) begin
            state <= IDLE;
            ch    <= '0;
            lat   <= '0;
            data  <= '0;
        end else begin
            case (state)
                IDLE: if (pending) begin
                    ch    <= '0;
                    state <= ISSUE;
                end
                ISSUE: begin
                    lat   <= LW'(READ_LATENCY - 1);
                    state <= WAIT;
                end
                WAIT: if (lat == '0) begin
                    data  <= bus.readdata[DATA_W-1:0];
                    state <= PUSH;
                end else begin
                    lat <= lat - 1'b1;
                end
                PUSH: if (ch == ADDR_W'(NUM_CH - 1)) begin
                    state <= IDLE;
                end else begin
                    ch    <= ch + 1'b1;
                    state <= ISSUE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MDA_ADC_POLLER_TIMESTAMP_EN
    logic [31:0] ts_cnt;
    logic [31:0] ts_sweep;

    // Free-running cycle counter, latched once when a sweep starts.
    always_ff @(posedge master_clk or negedge master_reset_n) begin
        if (!master_reset_n) begin
            ts_cnt   <= '0;
            ts_sweep <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
            if (state == IDLE && pending) ts_sweep <= ts_cnt;
        end
    end

    assign fifo_in = {ch, data, ts_sweep};
    assign {bus.sample_ch, bus.sample_data, bus.sample_ts} = fifo_out;
`else
    assign fifo_in = {ch, data};
    assign {bus.sample_ch, bus.sample_data} = fifo_out;
`endif

    mda_sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (master_clk),
        .rst_n (master_reset_n),
        .push  (push),
        .din   (fifo_in),
        .pop   (pop),
        .dout  (fifo_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );
endmodule

// File: tb/tb_mda_adc_poller.sv
// tb_mda_adc_poller: randomized self-checking bench for mda_adc_poller (covers MDA_ADC_POLLER_TIMESTAMP_EN when defined)
module tb_mda_adc_poller;
    import mda_adc_pkg::*;

    localparam int RL    = 3;
    localparam int PER   = 64;
    localparam int NCH   = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic enable = 1'b0;
    logic clear_flags = 1'b0;
    logic overflow, missed_sweep, busy;
    logic enable2 = 1'b0;
    logic clear2 = 1'b0;
    logic missed2, ovf2_unused, busy2_unused;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] mem [NCH];
    logic [11:0] sw [3][NCH];
    logic [RL-1:0] pv = '0;
    logic [RL-1:0][2:0] pa = '0;
    logic strobe, strobe2;
    adc_entry_t pe;
    adc_entry_t got_q[$];
    int st_cyc[$];
    logic [2:0] st_addr[$];
    int wr_bad = 0;
    int last2 = -1;
    int mingap2 = 1000;
    int maxgap2 = 0;

    mda_adc_poller_if #(.ADDR_W(3), .DATA_W(12)) bus ();
    mda_adc_poller_if #(.ADDR_W(3), .DATA_W(12)) bus2 ();

    mda_adc_poller #(.NUM_CH(NCH), .ADDR_W(3), .DATA_W(12), .READ_LATENCY(RL), .PERIOD(PER), .FIFO_DEPTH(DEPTH)) u_dut (
        .master_clk(clk), .master_reset_n(rst_n), .enable(enable), .clear_flags(clear_flags),
        .bus(bus.master), .overflow(overflow), .missed_sweep(missed_sweep), .busy(busy));

    mda_adc_poller #(.NUM_CH(NCH), .ADDR_W(3), .DATA_W(12), .READ_LATENCY(1), .PERIOD(20), .FIFO_DEPTH(DEPTH)) u_fast (
        .master_clk(clk), .master_reset_n(rst_n), .enable(enable2), .clear_flags(clear2),
        .bus(bus2.master), .overflow(ovf2_unused), .missed_sweep(missed2), .busy(busy2_unused));

    always #5 clk = ~clk;

    assign strobe  = !bus.chipselect_n && !bus.read_n;
    assign strobe2 = !bus2.chipselect_n && !bus2.read_n;

    // ADC slave: data is valid only exactly RL cycles after its strobe, X otherwise.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        pv  <= {pv[RL-2:0], strobe};
        pa  <= {pa[RL-2:0], bus.addr};
    end
    assign bus.readdata  = pv[RL-1] ? mem[pa[RL-1]] : 'x;
    assign bus2.readdata = 32'h0000_05A5;

    // Bus and stream monitors.
    always @(negedge clk) begin
        if (bus.write_n !== 1'b1 || bus.writedata !== 32'h0 || bus.chipselect_n !== bus.read_n) wr_bad <= wr_bad + 1;
        if (strobe) begin
            st_cyc.push_back(cyc);
            st_addr.push_back(bus.addr);
        end
        if (bus.sample_valid && bus.sample_ready) begin
            pe.ch   = bus.sample_ch;
            pe.data = bus.sample_data;
`ifdef MDA_ADC_POLLER_TIMESTAMP_EN
            pe.ts   = bus.sample_ts;
`endif
            got_q.push_back(pe);
        end
        if (strobe2) begin
            if (last2 >= 0 && cyc - last2 < mingap2) mingap2 <= cyc - last2;
            if (last2 >= 0 && cyc - last2 > maxgap2) maxgap2 <= cyc - last2;
            last2 <= cyc;
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        enable2 = 1'b0;
        clear_flags = 1'b0;
        clear2 = 1'b0;
        bus.sample_ready = 1'b0;
        bus2.sample_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        got_q.delete();
        st_cyc.delete();
        st_addr.delete();
        wr_bad = 0;
    endtask

    task automatic new_mem(input int s);
        for (int c = 0; c < NCH; c++) begin
            mem[c] = $urandom;
            sw[s][c] = mem[c][11:0];
        end
    endtask

    task automatic wait_sweep();
        int n;
        int m;
        for (n = 0; n < 2 * PER && !busy; n++) @(negedge clk);
        for (m = 0; m < 2 * PER && busy; m++) @(negedge clk);
        checks++;
        if (busy || n >= 2 * PER) begin errors++; $display("FAIL sweep_timeout busy %b waited %0d", busy, n); end
    endtask

    task automatic drain();
        int n;
        @(posedge clk);
        #1 bus.sample_ready = 1'b1;
        for (n = 0; n < 4 * DEPTH; n++) begin
            @(negedge clk);
            if (!bus.sample_valid) break;
        end
        @(posedge clk);
        #1 bus.sample_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.chipselect_n !== 1'b1 || bus.read_n !== 1'b1) begin errors++; $display("FAIL reset_strobes cs_n %b read_n %b exp 1 1", bus.chipselect_n, bus.read_n); end
        do_reset();
        @(negedge clk);
        checks++; if (bus.write_n !== 1'b1 || bus.writedata !== 32'h0 || bus.addr !== 3'd0) begin errors++; $display("FAIL reset_bus write_n %b wdata %h addr %0d exp 1 0 0", bus.write_n, bus.writedata, bus.addr); end
        checks++; if (bus.sample_valid !== 1'b0 || bus.sample_ch !== 3'd0 || bus.sample_data !== 12'h0) begin errors++; $display("FAIL reset_stream valid %b ch %0d data %h exp 0 0 0", bus.sample_valid, bus.sample_ch, bus.sample_data); end
        checks++; if (overflow !== 1'b0 || missed_sweep !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_flags ovf %b missed %b busy %b exp 0 0 0", overflow, missed_sweep, busy); end
    endtask

    task automatic test_sweep();
        int n;
        int m;
        do_reset();
        for (int c = 0; c < NCH; c++) begin
            mem[c] = ($urandom & 32'hFFFF_F000) | (32'h100 + c);
            sw[0][c] = mem[c][11:0];
        end
        bus.sample_ready = 1'b1;
        enable = 1'b1;
        n = 0;
        do begin @(posedge clk); n++; @(negedge clk); end while (!strobe && n < 3 * PER);
        checks++; if (n !== PER + 1) begin errors++; $display("FAIL first_strobe cycles %0d exp %0d", n, PER + 1); end
        m = 0;
        do begin @(posedge clk); m++; @(negedge clk); end while (busy && m < 3 * PER);
        checks++; if (m !== NCH * (RL + 2)) begin errors++; $display("FAIL busy_len cycles %0d exp %0d", m, NCH * (RL + 2)); end
        repeat (4) @(negedge clk);
        enable = 1'b0;
        checks++; if (got_q.size() !== NCH) begin errors++; $display("FAIL sweep_count got %0d exp %0d", got_q.size(), NCH); end
        for (int i = 0; i < NCH && i < got_q.size(); i++) begin
            checks++; if (got_q[i].ch !== 3'(i) || got_q[i].data !== sw[0][i]) begin errors++; $display("FAIL sweep_entry %0d got ch %0d data %h exp ch %0d data %h", i, got_q[i].ch, got_q[i].data, i, sw[0][i]); end
        end
        checks++; if (st_addr.size() !== NCH) begin errors++; $display("FAIL strobe_count got %0d exp %0d", st_addr.size(), NCH); end
        for (int i = 0; i < NCH && i < st_addr.size(); i++) begin
            checks++; if (st_addr[i] !== 3'(i)) begin errors++; $display("FAIL strobe_addr %0d got %0d exp %0d", i, st_addr[i], i); end
            if (i > 0) begin
                checks++; if (st_cyc[i] - st_cyc[i-1] !== RL + 2) begin errors++; $display("FAIL strobe_gap %0d got %0d exp %0d", i, st_cyc[i] - st_cyc[i-1], RL + 2); end
            end
        end
        checks++; if (wr_bad !== 0 || missed_sweep !== 1'b0) begin errors++; $display("FAIL bus_idle_sigs bad %0d missed %b exp 0 0", wr_bad, missed_sweep); end
    endtask

    task automatic test_overflow();
        do_reset();
        new_mem(0);
        enable = 1'b1;
        wait_sweep();
        new_mem(1);
        wait_sweep();
        new_mem(2);
        wait_sweep();
        enable = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got %b exp 1", overflow); end
        drain();
        checks++; if (got_q.size() !== DEPTH) begin errors++; $display("FAIL overflow_kept got %0d exp %0d", got_q.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < got_q.size(); i++) begin
            checks++; if (got_q[i].ch !== 3'(i % NCH) || got_q[i].data !== sw[i / NCH][i % NCH]) begin errors++; $display("FAIL overflow_entry %0d got ch %0d data %h exp ch %0d data %h", i, got_q[i].ch, got_q[i].data, i % NCH, sw[i / NCH][i % NCH]); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b exp 1", overflow); end
        @(posedge clk);
        #1 clear_flags = 1'b1;
        @(posedge clk);
        #1 clear_flags = 1'b0;
        @(negedge clk);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear got %b exp 0", overflow); end
    endtask

    task automatic test_missed_sweep();
        do_reset();
        last2 = -1;
        mingap2 = 1000;
        maxgap2 = 0;
        enable2 = 1'b1;
        repeat (200) @(negedge clk);
        checks++; if (missed2 !== 1'b1) begin errors++; $display("FAIL missed_set got %b exp 1", missed2); end
        checks++; if (mingap2 !== 3 || maxgap2 !== 4) begin errors++; $display("FAIL back_to_back gaps min %0d max %0d exp 3 4", mingap2, maxgap2); end
        enable2 = 1'b0;
        @(posedge clk);
        #1 clear2 = 1'b1;
        @(posedge clk);
        #1 clear2 = 1'b0;
        @(negedge clk);
        checks++; if (missed2 !== 1'b0) begin errors++; $display("FAIL missed_clear got %b exp 0", missed2); end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        do_reset();
        new_mem(0);
        enable = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!(strobe && bus.addr == 3'd5) && n < 3 * PER);
        checks++; if (bus.sample_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b exp 1", bus.sample_valid); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.chipselect_n !== 1'b1 || bus.read_n !== 1'b1 || bus.sample_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL async_reset cs_n %b read_n %b valid %b busy %b exp 1 1 0 0", bus.chipselect_n, bus.read_n, bus.sample_valid, busy); end
        #1 rst_n = 1'b1;
        n = 0;
        do begin @(posedge clk); n++; @(negedge clk); end while (!strobe && n < 3 * PER);
        checks++; if (n !== PER + 1 || bus.addr !== 3'd0) begin errors++; $display("FAIL restart cycles %0d addr %0d exp %0d 0", n, bus.addr, PER + 1); end
        enable = 1'b0;
        repeat (2 * PER) @(negedge clk);
    endtask

    task automatic test_full_pop_push();
        int n;
        do_reset();
        new_mem(0);
        enable = 1'b1;
        wait_sweep();
        new_mem(1);
        wait_sweep();
        new_mem(2);
        checks++; if (overflow !== 1'b0 || bus.sample_valid !== 1'b1) begin errors++; $display("FAIL full_no_ovf ovf %b valid %b exp 0 1", overflow, bus.sample_valid); end
        for (int k = 0; k < NCH; k++) begin
            n = 0;
            while (!strobe && n < 2 * PER) begin @(negedge clk); n++; end
            repeat (RL + 1) @(posedge clk);
            #1 bus.sample_ready = 1'b1;
            if (k == 0) enable = 1'b0;
            @(posedge clk);
            #1 bus.sample_ready = 1'b0;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pop_push_ovf got %b exp 0", overflow); end
        checks++; if (got_q.size() !== NCH) begin errors++; $display("FAIL pop_push_pops got %0d exp %0d", got_q.size(), NCH); end
        drain();
        checks++; if (got_q.size() !== 3 * NCH) begin errors++; $display("FAIL pop_push_total got %0d exp %0d", got_q.size(), 3 * NCH); end
        for (int i = 0; i < 3 * NCH && i < got_q.size(); i++) begin
            checks++; if (got_q[i].ch !== 3'(i % NCH) || got_q[i].data !== sw[i / NCH][i % NCH]) begin errors++; $display("FAIL pop_push_entry %0d got ch %0d data %h exp ch %0d data %h", i, got_q[i].ch, got_q[i].data, i % NCH, sw[i / NCH][i % NCH]); end
`ifdef MDA_ADC_POLLER_TIMESTAMP_EN
            if (i % NCH != 0) begin
                checks++; if (got_q[i].ts !== got_q[i - i % NCH].ts) begin errors++; $display("FAIL ts_shared %0d got %0d exp %0d", i, got_q[i].ts, got_q[i - i % NCH].ts); end
            end else if (i > 0) begin
                checks++; if (got_q[i].ts - got_q[i - NCH].ts !== 32'(PER)) begin errors++; $display("FAIL ts_step %0d got %0d exp %0d", i, got_q[i].ts - got_q[i - NCH].ts, PER); end
            end
`endif
        end
    endtask

    initial begin
        for (int c = 0; c < NCH; c++) mem[c] = '0;
        bus.sample_ready = 1'b0;
        bus2.sample_ready = 1'b1;
        test_reset();
        test_sweep();
        test_overflow();
        test_missed_sweep();
        test_reset_mid_sweep();
        test_full_pop_push();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
